dff_debounce: RTL and testbench

Debounce and edge-detect stage downstream of the structural D flip-flop cells. Takes the raw, possibly bouncing or asynchronous `q` level from a flip-flop or latch cell. Emits a clean, registered level with its complement, plus single-cycle rise and fall pulses for the control logic. Filtering uses a stability counter inside a four-state FSM.

---
 rtl/dff_debounce.sv | 152 +++++++++++++++
 tb/tb_dff_debounce.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dff_debounce.sv
// Debounce and edge-detect stage for a raw flip-flop/latch level.
// Optional two-flop input synchronizer enabled by defining DEBOUNCE_SYNC_EN.
module dff_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES);
  localparam logic             SKIP_PEND = (STABLE_CYCLES == 32'sd1);

  logic             samp_s;
  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s, cnt_inc_s;
  logic             rise_nx_s, fall_nx_s, q_nx_s, busy_nx_s;
  logic             q_r, qbar_r, rise_r, fall_r, busy_r;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_r, sync2_r;

  // Two-flop synchronizer for a d that is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= d;
      sync2_r <= sync1_r;
    end
  end

  assign samp_s = sync2_r;
`else
  assign samp_s = d;
`endif

  // cnt holds the number of matching samples already seen; the current one makes cnt+1.
  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Next-state, counter and pulse logic of the filter FSM.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    rise_nx_s  = 1'b0;
    fall_nx_s  = 1'b0;
    case (state_r)
      ST_LOW: begin
        if (samp_s) begin
          if (SKIP_PEND) begin
            state_nx_s = ST_HIGH;
            rise_nx_s  = 1'b1;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            state_nx_s = ST_RISE_PEND;
            cnt_nx_s   = CNT_ONE;
          end
        end else begin
          cnt_nx_s = CNT_ZERO;
        end
      end
      ST_RISE_PEND: begin
        if (!samp_s) begin
          state_nx_s = ST_LOW;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_inc_s == CNT_LAST) begin
          state_nx_s = ST_HIGH;
          rise_nx_s  = 1'b1;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_inc_s;
        end
      end
      ST_HIGH: begin
        if (!samp_s) begin
          if (SKIP_PEND) begin
            state_nx_s = ST_LOW;
            fall_nx_s  = 1'b1;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            state_nx_s = ST_FALL_PEND;
            cnt_nx_s   = CNT_ONE;
          end
        end else begin
          cnt_nx_s = CNT_ZERO;
        end
      end
      ST_FALL_PEND: begin
        if (samp_s) begin
          state_nx_s = ST_HIGH;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_inc_s == CNT_LAST) begin
          state_nx_s = ST_LOW;
          fall_nx_s  = 1'b1;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_inc_s;
        end
      end
      default: begin
        state_nx_s = ST_LOW;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
    q_nx_s    = (state_nx_s == ST_HIGH) || (state_nx_s == ST_FALL_PEND);
    busy_nx_s = (state_nx_s == ST_RISE_PEND) || (state_nx_s == ST_FALL_PEND);
  end

  // State, counter and registered outputs; q and qbar load from the same next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOW;
      cnt_r   <= CNT_ZERO;
      q_r     <= 1'b0;
      qbar_r  <= 1'b1;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      q_r     <= q_nx_s;
      qbar_r  <= ~q_nx_s;
      rise_r  <= rise_nx_s;
      fall_r  <= fall_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign q    = q_r;
  assign qbar = qbar_r;
  assign rise = rise_r;
  assign fall = fall_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_dff_debounce.sv
// Directed self-checking bench for dff_debounce (STABLE_CYCLES=4 and =1 instances).
module tb_dff_debounce;

`ifdef DEBOUNCE_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d4 = 1'b0, q4, qb4, r4, f4, b4;
  logic d1 = 1'b0, q1, qb1, r1, f1, b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic hist [0:63];
  logic exp_q, prev_q;

  always #5 clk = ~clk;

  dff_debounce #(.STABLE_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .d(d4), .q(q4), .qbar(qb4),
    .rise(r4), .fall(f4), .busy(b4)
  );

  dff_debounce #(.STABLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .q(q1), .qbar(qb1),
    .rise(r1), .fall(f1), .busy(b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_q4", q4, 1'b0);   chk("rst_qb4", qb4, 1'b1);
    chk("rst_r4", r4, 1'b0);   chk("rst_f4", f4, 1'b0);
    chk("rst_b4", b4, 1'b0);
    chk("rst_q1", q1, 1'b0);   chk("rst_qb1", qb1, 1'b1);
    rst_n = 1'b1;
    tick();

    // Clean rise
    d4 = 1'b1;
    for (int i = 1; i <= D + 3; i++) begin
      tick();
      chk("rise_wait_q", q4, 1'b0);
      chk("rise_wait_r", r4, 1'b0);
      chk("rise_wait_b", b4, (i >= D + 1) ? 1'b1 : 1'b0);
    end
    tick();
    chk("rise_q", q4, 1'b1);  chk("rise_r", r4, 1'b1);
    chk("rise_qb", qb4, 1'b0); chk("rise_b", b4, 1'b0);
    tick();
    chk("rise_r_end", r4, 1'b0); chk("rise_q_hold", q4, 1'b1);

    // Clean fall, same latency
    d4 = 1'b0;
    for (int i = 1; i <= D + 3; i++) begin
      tick();
      chk("fall_wait_q", q4, 1'b1);
      chk("fall_wait_f", f4, 1'b0);
    end
    tick();
    chk("fall_q", q4, 1'b0);  chk("fall_f", f4, 1'b1);
    chk("fall_qb", qb4, 1'b1); chk("fall_r", r4, 1'b0);
    tick();
    chk("fall_f_end", f4, 1'b0);

    // Bounce reject: 1,1,1,0,1,1,1,1 then held high
    begin
      logic pat [0:7];
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int t = 1; t <= 14; t++) begin
        d4 = (t <= 8) ? pat[t-1] : 1'b1;
        tick();
        chk("bnc_rise", r4, (t == 8 + D) ? 1'b1 : 1'b0);
        chk("bnc_fall", f4, 1'b0);
        if (t == D + 3) chk("bnc_busy_pend", b4, 1'b1);
        if (t == D + 4) chk("bnc_busy_rej", b4, 1'b0);
      end
      chk("bnc_q", q4, 1'b1);
    end
    d4 = 1'b0;
    for (int i = 0; i < D + 6; i++) tick();
    chk("bnc_back_low", q4, 1'b0);

    // Square wave, period 6: never stable for 4 samples
    for (int t = 0; t < 36; t++) begin
      d4 = ((t / 3) % 2 == 0) ? 1'b1 : 1'b0;
      hist[t] = d4;
      tick();
      chk("sq_q", q4, 1'b0);
      chk("sq_r", r4, 1'b0);
      chk("sq_f", f4, 1'b0);
      chk("sq_busy", b4, (t - D >= 0) ? hist[t-D] : 1'b0);
    end
    d4 = 1'b0;
    for (int i = 0; i < D + 2; i++) tick();

    // STABLE_CYCLES=1: q follows d, one pulse per toggle
    prev_q = 1'b0;
    for (int t = 0; t < 16; t++) begin
      d1 = ((t >> 1) % 2 == 1) ? 1'b1 : 1'b0;
      hist[t] = d1;
      tick();
      exp_q = (t - D >= 0) ? hist[t-D] : 1'b0;
      chk("s1_q", q1, exp_q);
      chk("s1_qb", qb1, ~exp_q);
      chk("s1_rise", r1, exp_q & ~prev_q);
      chk("s1_fall", f1, ~exp_q & prev_q);
      chk("s1_busy", b1, 1'b0);
      prev_q = exp_q;
    end
    d1 = 1'b0;

    // Async reset from HIGH, then mid-RISE_PEND with cnt=3
    d4 = 1'b1;
    for (int i = 0; i < D + 4; i++) tick();
    chk("pre_rst_high", q4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_q", q4, 1'b0);  chk("arst_qb", qb4, 1'b1);
    chk("arst_b", b4, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= D + 3; i++) begin
      tick();
      chk("post_rst_r", r4, 1'b0);
      chk("post_rst_q", q4, 1'b0);
    end
    chk("mid_pend_busy", b4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("pend_rst_q", q4, 1'b0); chk("pend_rst_qb", qb4, 1'b1);
    chk("pend_rst_b", b4, 1'b0);
    d4 = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("quiet_r", r4, 1'b0);
      chk("quiet_f", f4, 1'b0);
      chk("quiet_q", q4, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
